pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge system clock; rst in 1, reset, synchronous, active-high.
REQ-002 SHALL have ports: id_rs1_addr in `RegAddr (4), ID source-1 register; id_rs1_use in 1, source-1 valid; id_rs2_addr in 4; id_rs2_use in 1.
REQ-003 SHALL have ports: ex_mem_read in 1, EXE-stage instruction is a load; ex_reg_addr in 4, EXE destination (4'hF = none); branch_taken in 1, ID resolved a taken branch/jump.
REQ-004 SHALL have ports: mem_ram1 in 1, MEM-stage access targets the instruction RAM; mem_busy in 1, external SRAM/UART not ready.
REQ-005 SHALL have ports: pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_flush, exe_mem_hold, mem_wb_flush out 1 each, stage controls; state out 2; timeout_err out 1, sticky.

Function
REQ-006 SHALL implement states RUN=2'b00, BUBBLE=2'b01, STRUCT=2'b10, WAIT=2'b11, registered on clk, driven on state.
REQ-007 Stage-control outputs SHALL be combinational from the current state and the current inputs, with zero-cycle latency.
REQ-008 Priority per cycle SHALL be: mem_busy > mem_ram1 > load-use > branch_taken.
REQ-009 mem_busy=1: pc_hold, if_id_hold, id_exe_hold and exe_mem_hold =1; mem_wb_flush=1; next state WAIT.
REQ-010 WAIT SHALL persist while mem_busy=1 and return to RUN in the cycle after mem_busy drops.
REQ-011 mem_ram1=1 with mem_busy=0: pc_hold=1 and if_id_flush=1 (the fetch slot is lost); next state STRUCT for exactly one cycle, then RUN.
REQ-012 Load-use SHALL be: ex_mem_read & ex_reg_addr!=4'hF & ((id_rs1_use & id_rs1_addr==ex_reg_addr) | (id_rs2_use & id_rs2_addr==ex_reg_addr)).
REQ-013 Load-use: pc_hold=1, if_id_hold=1, id_exe_flush=1 (one NOP bubble); next state BUBBLE.
REQ-014 In BUBBLE, load-use SHALL NOT re-trigger (the EXE slot now holds the NOP); the state returns to RUN after one cycle.
REQ-015 branch_taken with no higher-priority event: if_id_flush=1 only; PC is not held.
REQ-016 branch_taken while any stall is active SHALL be ignored; ID is held, so the branch re-asserts and is serviced when the stall clears.
REQ-017 Hold and flush SHALL never both be asserted on the same stage register; where they conflict, hold wins.
REQ-018 An 8-bit wait counter SHALL increment each cycle in WAIT, saturate at 255 and clear on WAIT exit.
REQ-019 timeout_err SHALL set when the wait counter reaches 255 and stay set until rst.

Reset
REQ-020 rst=1 SHALL force state=RUN, the wait counter to 0, timeout_err=0 and the statistics counters to 0.
REQ-021 While rst=1, all hold outputs SHALL be 0 and if_id_flush, id_exe_flush and mem_wb_flush SHALL be 1, so the pipe fills with NOPs.
REQ-022 rst asserted mid-WAIT or mid-BUBBLE SHALL abort the operation; RUN starts on the first cycle after rst deasserts.

Configuration
REQ-023 With PIPE_STATS_EN defined, the block SHALL add outputs stall_cnt[15:0] (cycles with pc_hold=1) and flush_cnt[15:0] (cycles with any flush=1), both wrapping at 16'hFFFF->0.
REQ-024 Without PIPE_STATS_EN, the counters and ports SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-025 `RegAddr, `RegValue, the state encodings PC_RUN, PC_BUBBLE, PC_STRUCT, PC_WAIT and the no-register code 4'hF SHALL live in define.v.
REQ-026 Load-use comparison SHALL be a sub-module hazard_detect (pure combinational); the FSM and counters SHALL stay in pipe_ctrl.

Verification
REQ-027 Load-use: ex_mem_read=1, ex_reg_addr=3, id_rs1_use=1, id_rs1_addr=3 -> cycle 0: pc_hold=1, if_id_hold=1, id_exe_flush=1, state->BUBBLE; cycle 1 with the same ID inputs and ex_mem_read=0 -> all controls 0, state->RUN.
REQ-028 No false hazard: ex_reg_addr=4'hF, id_rs1_addr=4'hF, ex_mem_read=1 -> all controls 0.
REQ-029 Structural plus branch: mem_ram1=1 and branch_taken=1 together -> pc_hold=1, if_id_flush=1, state STRUCT for one cycle; the branch flush is serviced on the next cycle.
REQ-030 Busy: mem_busy=1 for 4 cycles -> all four holds=1 for 4 cycles and mem_wb_flush=1; state=WAIT; RUN returns on cycle 5; timeout_err=0.
REQ-031 Timeout: mem_busy=1 for 300 cycles -> timeout_err=1 from cycle 256 and it remains 1 after mem_busy drops, until rst.
REQ-032 Stats (PIPE_STATS_EN): 3 load-use events plus 2 branches -> stall_cnt=3 and flush_cnt=5; rst mid-WAIT -> both counters 0 and state=RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// State encodings, register-address types and the stage-control bundle.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W  = 4;
    localparam int REG_VALUE_W = 32;

    typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
    typedef logic [REG_VALUE_W-1:0] reg_value_t;

    // Destination code meaning "writes no register"
    localparam reg_addr_t REG_NONE = 4'hF;

    localparam logic [7:0] WAIT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        PC_RUN    = 2'b00,
        PC_BUBBLE = 2'b01,
        PC_STRUCT = 2'b10,
        PC_WAIT   = 2'b11
    } pc_state_e;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_exe_hold;
        logic id_exe_flush;
        logic exe_mem_hold;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    // A held register keeps its contents, so a flush on it is dropped.
    function automatic pipe_ctrl_t resolve(input pipe_ctrl_t c);
        pipe_ctrl_t r;
        r = c;
        r.if_id_flush  = c.if_id_flush  & ~c.if_id_hold;
        r.id_exe_flush = c.id_exe_flush & ~c.id_exe_hold;
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID sources and the EXE load target.
// Ports: id_rs1/rs2 addr+use, ex_mem_read, ex_reg_addr in; load_use out.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  reg_addr_t id_rs1_addr,
    input  logic      id_rs1_use,
    input  reg_addr_t id_rs2_addr,
    input  logic      id_rs2_use,
    input  logic      ex_mem_read,
    input  reg_addr_t ex_reg_addr,
    output logic      load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_use & (id_rs1_addr == ex_reg_addr);
    assign rs2_hit  = id_rs2_use & (id_rs2_addr == ex_reg_addr);
    assign load_use = ex_mem_read & (ex_reg_addr != REG_NONE)
                    & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: memory wait, structural, load-use, branch.
// Ports: clk, rst, ID/EXE/MEM hazard inputs; stage controls, state, timeout_err
// out. PIPE_STATS_EN adds stall_cnt/flush_cnt.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  reg_addr_t   id_rs1_addr,
    input  logic        id_rs1_use,
    input  reg_addr_t   id_rs2_addr,
    input  logic        id_rs2_use,
    input  logic        ex_mem_read,
    input  reg_addr_t   ex_reg_addr,
    input  logic        branch_taken,
    input  logic        mem_ram1,
    input  logic        mem_busy,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_exe_hold,
    output logic        id_exe_flush,
    output logic        exe_mem_hold,
    output logic        mem_wb_flush,
    output logic [1:0]  state,
`ifdef PIPE_STATS_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic        timeout_err
);

    pc_state_e  state_q;
    pc_state_e  state_d;
    pipe_ctrl_t ctrl;
    pipe_ctrl_t raw;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_d;
    logic       load_use;
    logic       ev_busy;
    logic       ev_struct;
    logic       ev_lu;
    logic       ev_br;
    logic       ev_none;

    hazard_detect u_hazard (
        .id_rs1_addr (id_rs1_addr),
        .id_rs1_use  (id_rs1_use),
        .id_rs2_addr (id_rs2_addr),
        .id_rs2_use  (id_rs2_use),
        .ex_mem_read (ex_mem_read),
        .ex_reg_addr (ex_reg_addr),
        .load_use    (load_use)
    );

    // One-hot event after priority; in BUBBLE the EXE slot holds the NOP,
    // so a lingering load-use match is stale.
    assign ev_busy   = mem_busy;
    assign ev_struct = ~mem_busy & mem_ram1;
    assign ev_lu     = ~mem_busy & ~mem_ram1 & load_use
                     & (state_q != PC_BUBBLE);
    assign ev_br     = ~mem_busy & ~mem_ram1 & ~ev_lu & branch_taken;
    assign ev_none   = ~(ev_busy | ev_struct | ev_lu | ev_br);

    always_comb begin
        raw     = '0;
        state_d = PC_RUN;
        if (rst) begin
            raw.if_id_flush  = 1'b1;
            raw.id_exe_flush = 1'b1;
            raw.mem_wb_flush = 1'b1;
        end else begin
            unique case (1'b1)
                ev_busy: begin
                    raw.pc_hold      = 1'b1;
                    raw.if_id_hold   = 1'b1;
                    raw.id_exe_hold  = 1'b1;
                    raw.exe_mem_hold = 1'b1;
                    raw.mem_wb_flush = 1'b1;
                    state_d          = PC_WAIT;
                end
                ev_struct: begin
                    raw.pc_hold     = 1'b1;
                    raw.if_id_flush = 1'b1;
                    state_d         = PC_STRUCT;
                end
                ev_lu: begin
                    raw.pc_hold      = 1'b1;
                    raw.if_id_hold   = 1'b1;
                    raw.id_exe_flush = 1'b1;
                    state_d          = PC_BUBBLE;
                end
                ev_br: begin
                    raw.if_id_flush = 1'b1;
                end
                ev_none: begin
                    state_d = PC_RUN;
                end
                default: begin
                    state_d = PC_RUN;
                end
            endcase
        end
        ctrl = resolve(raw);
    end

    // Counts only cycles that stay in WAIT; leaving WAIT clears it.
    always_comb begin
        wait_cnt_d = 8'd0;
        if (state_q == PC_WAIT && mem_busy) begin
            wait_cnt_d = (wait_cnt == WAIT_MAX) ? WAIT_MAX
                                                : wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PC_RUN;
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt    <= wait_cnt_d;
            timeout_err <= timeout_err | (wait_cnt_d == WAIT_MAX);
        end
    end

`ifdef PIPE_STATS_EN
    logic any_flush;

    assign any_flush = ctrl.if_id_flush | ctrl.id_exe_flush
                     | ctrl.mem_wb_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (ctrl.pc_hold)
                stall_cnt <= stall_cnt + 16'd1;
            if (any_flush)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

    assign pc_hold      = ctrl.pc_hold;
    assign if_id_hold   = ctrl.if_id_hold;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_exe_hold  = ctrl.id_exe_hold;
    assign id_exe_flush = ctrl.id_exe_flush;
    assign exe_mem_hold = ctrl.exe_mem_hold;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign state        = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl.
// Expected controls/state are queued per driven cycle and checked at negedge.
module tb_pipe_ctrl;

    typedef struct packed {
        logic       busy;
        logic       ram1;
        logic       br;
        logic       mr;
        logic [3:0] ex_rd;
        logic       u1;
        logic [3:0] a1;
        logic       u2;
        logic [3:0] a2;
    } stim_t;

    typedef struct {
        string      tag;
        logic [6:0] ctrl;
        logic [1:0] st;
        logic       to;
    } exp_t;

    // {pc_hold, if_id_hold, if_id_flush, id_exe_hold,
    //  id_exe_flush, exe_mem_hold, mem_wb_flush}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_RST  = 7'b0010101;
    localparam logic [6:0] C_BUSY = 7'b1101011;
    localparam logic [6:0] C_STR  = 7'b1010000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0010000;

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_BUB = 2'b01;
    localparam logic [1:0] S_STR = 2'b10;
    localparam logic [1:0] S_WT  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] id_rs1_addr = '0;
    logic       id_rs1_use = 1'b0;
    logic [3:0] id_rs2_addr = '0;
    logic       id_rs2_use = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [3:0] ex_reg_addr = 4'hF;
    logic       branch_taken = 1'b0;
    logic       mem_ram1 = 1'b0;
    logic       mem_busy = 1'b0;
    logic       pc_hold, if_id_hold, if_id_flush, id_exe_hold;
    logic       id_exe_flush, exe_mem_hold, mem_wb_flush;
    logic [1:0] state;
    logic       timeout_err;
`ifdef PIPE_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs1_use   (id_rs1_use),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs2_use   (id_rs2_use),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_addr  (ex_reg_addr),
        .branch_taken (branch_taken),
        .mem_ram1     (mem_ram1),
        .mem_busy     (mem_busy),
        .pc_hold      (pc_hold),
        .if_id_hold   (if_id_hold),
        .if_id_flush  (if_id_flush),
        .id_exe_hold  (id_exe_hold),
        .id_exe_flush (id_exe_flush),
        .exe_mem_hold (exe_mem_hold),
        .mem_wb_flush (mem_wb_flush),
        .state        (state),
`ifdef PIPE_STATS_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic stim_t mk(input logic busy, input logic ram1,
                                 input logic br, input logic mr,
                                 input logic [3:0] ex_rd,
                                 input logic u1, input logic [3:0] a1,
                                 input logic u2, input logic [3:0] a2);
        stim_t s;
        s = '{busy, ram1, br, mr, ex_rd, u1, a1, u2, a2};
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 4'hF, 0, 4'h0, 0, 4'h0);
    endfunction

    task automatic step(input string tag, input logic r, input stim_t s,
                        input logic [6:0] c, input logic [1:0] st,
                        input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        mem_busy     = s.busy;
        mem_ram1     = s.ram1;
        branch_taken = s.br;
        ex_mem_read  = s.mr;
        ex_reg_addr  = s.ex_rd;
        id_rs1_use   = s.u1;
        id_rs1_addr  = s.a1;
        id_rs2_use   = s.u2;
        id_rs2_addr  = s.a2;
        e.tag  = tag;
        e.ctrl = c;
        e.st   = st;
        e.to   = to;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_ctrl"},
                32'({pc_hold, if_id_hold, if_id_flush, id_exe_hold,
                     id_exe_flush, exe_mem_hold, mem_wb_flush}),
                32'(e.ctrl));
            chk({e.tag, "_state"}, 32'(state), 32'(e.st));
            chk({e.tag, "_to"}, 32'(timeout_err), 32'(e.to));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        stim_t lu3;
        lu3 = mk(0, 0, 0, 1, 4'd3, 1, 4'd3, 0, 4'd0);

        step("rst0", 1, idle(), C_RST, S_RUN, 0);
        step("rst1", 1, lu3, C_RST, S_RUN, 0);
        step("idle", 0, idle(), C_NONE, S_RUN, 0);

        // load-use on rs1, then EXE no longer a load
        step("lu_c0", 0, lu3, C_LU, S_RUN, 0);
        step("lu_c1", 0, mk(0, 0, 0, 0, 4'd3, 1, 4'd3, 0, 4'd0),
             C_NONE, S_BUB, 0);
        step("lu_c2", 0, idle(), C_NONE, S_RUN, 0);

        // stale match in BUBBLE must not retrigger
        step("lu_again", 0, lu3, C_LU, S_RUN, 0);
        step("bub_stale", 0, lu3, C_NONE, S_BUB, 0);
        step("bub_exit", 0, idle(), C_NONE, S_RUN, 0);

        // rs2 hazard, use-bit gating, no-register code
        step("lu_rs2", 0, mk(0, 0, 0, 1, 4'd7, 0, 4'd0, 1, 4'd7),
             C_LU, S_RUN, 0);
        step("rs2_bub", 0, idle(), C_NONE, S_BUB, 0);
        step("rs1_unused", 0, mk(0, 0, 0, 1, 4'd5, 0, 4'd5, 0, 4'd0),
             C_NONE, S_RUN, 0);
        step("no_reg", 0, mk(0, 0, 0, 1, 4'hF, 1, 4'hF, 1, 4'hF),
             C_NONE, S_RUN, 0);
        step("no_load", 0, mk(0, 0, 0, 0, 4'd2, 1, 4'd2, 0, 4'd0),
             C_NONE, S_RUN, 0);

        // structural + branch, branch serviced after STRUCT
        step("str_br", 0, mk(0, 1, 1, 0, 4'hF, 0, 0, 0, 0),
             C_STR, S_RUN, 0);
        step("br_after", 0, mk(0, 0, 1, 0, 4'hF, 0, 0, 0, 0),
             C_BR, S_STR, 0);
        step("br_idle", 0, idle(), C_NONE, S_RUN, 0);
        step("br_alone", 0, mk(0, 0, 1, 0, 4'hF, 0, 0, 0, 0),
             C_BR, S_RUN, 0);
        step("br_next", 0, idle(), C_NONE, S_RUN, 0);

        // load-use beats branch; branch taken in BUBBLE
        step("lu_br", 0, mk(0, 0, 1, 1, 4'd3, 1, 4'd3, 0, 4'd0),
             C_LU, S_RUN, 0);
        step("bub_br", 0, mk(0, 0, 1, 1, 4'd3, 1, 4'd3, 0, 4'd0),
             C_BR, S_BUB, 0);
        step("bub_br_x", 0, idle(), C_NONE, S_RUN, 0);

        // busy for 4 cycles, everything else asserted too
        step("busy0", 0, mk(1, 1, 1, 1, 4'd3, 1, 4'd3, 0, 4'd0),
             C_BUSY, S_RUN, 0);
        for (int i = 1; i < 4; i++)
            step($sformatf("busy%0d", i), 0,
                 mk(1, 0, 0, 0, 4'hF, 0, 0, 0, 0), C_BUSY, S_WT, 0);
        step("busy_drop", 0, idle(), C_NONE, S_WT, 0);
        step("busy_run", 0, idle(), C_NONE, S_RUN, 0);

        // rst aborts WAIT and BUBBLE
        step("rw_b0", 0, mk(1, 0, 0, 0, 4'hF, 0, 0, 0, 0),
             C_BUSY, S_RUN, 0);
        step("rw_b1", 0, mk(1, 0, 0, 0, 4'hF, 0, 0, 0, 0),
             C_BUSY, S_WT, 0);
        step("rw_rst", 1, mk(1, 0, 0, 0, 4'hF, 0, 0, 0, 0),
             C_RST, S_WT, 0);
        step("rw_run", 0, idle(), C_NONE, S_RUN, 0);
        step("rb_lu", 0, lu3, C_LU, S_RUN, 0);
        step("rb_rst", 1, lu3, C_RST, S_BUB, 0);
        step("rb_run", 0, idle(), C_NONE, S_RUN, 0);

        // 300-cycle wait: timeout from cycle 256, sticky until rst
        for (int c = 0; c < 300; c++)
            step($sformatf("tmo%0d", c), 0,
                 mk(1, 0, 0, 0, 4'hF, 0, 0, 0, 0), C_BUSY,
                 (c == 0) ? S_RUN : S_WT, (c >= 256) ? 1'b1 : 1'b0);
        step("tmo_drop", 0, idle(), C_NONE, S_WT, 1);
        step("tmo_run", 0, idle(), C_NONE, S_RUN, 1);
        step("tmo_hold", 0, idle(), C_NONE, S_RUN, 1);
        step("tmo_rst", 1, idle(), C_RST, S_RUN, 1);
        step("tmo_clr", 0, idle(), C_NONE, S_RUN, 0);

`ifdef PIPE_STATS_EN
        step("st_rst", 1, idle(), C_RST, S_RUN, 0);
        for (int k = 0; k < 3; k++) begin
            step("st_lu", 0, lu3, C_LU, S_RUN, 0);
            step("st_bub", 0, idle(), C_NONE, S_BUB, 0);
        end
        for (int k = 0; k < 2; k++)
            step("st_br", 0, mk(0, 0, 1, 0, 4'hF, 0, 0, 0, 0),
                 C_BR, S_RUN, 0);
        step("st_idle", 0, idle(), C_NONE, S_RUN, 0);
        @(negedge clk);
        chk("stall_cnt", 32'(stall_cnt), 32'd3);
        chk("flush_cnt", 32'(flush_cnt), 32'd5);
        step("st_w0", 0, mk(1, 0, 0, 0, 4'hF, 0, 0, 0, 0),
             C_BUSY, S_RUN, 0);
        step("st_w1", 0, mk(1, 0, 0, 0, 4'hF, 0, 0, 0, 0),
             C_BUSY, S_WT, 0);
        step("st_wrst", 1, mk(1, 0, 0, 0, 4'hF, 0, 0, 0, 0),
             C_RST, S_WT, 0);
        step("st_after", 0, idle(), C_NONE, S_RUN, 0);
        @(negedge clk);
        chk("stall_clr", 32'(stall_cnt), 32'd0);
        chk("flush_clr", 32'(flush_cnt), 32'd0);
`endif

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
